// File: rtl/switch_debouncer.sv
// Two-flop synchroniser plus per-bit stability-counter debouncer with registered rise/fall pulses.
// Optional sticky per-bit event flags and IRQ are enabled with `define SWITCH_EVENT_LATCH_EN.
module switch_debouncer #(
    parameter int WIDTH         = 8,
    parameter int STABLE_CYCLES = 500000,
    parameter int CNT_W         = 20
) (
    input  logic             clk_clk,
    input  logic             reset_reset_n,
    input  logic [WIDTH-1:0] sw_raw,
    output logic [WIDTH-1:0] sw_debounced,
    output logic [WIDTH-1:0] sw_rise,
    output logic [WIDTH-1:0] sw_fall,
    output logic             sw_changed
`ifdef SWITCH_EVENT_LATCH_EN
    ,
    input  logic [WIDTH-1:0] evt_clear,
    output logic [WIDTH-1:0] evt_pending,
    output logic             evt_irq
`endif
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic [WIDTH-1:0] sync1;
    logic [WIDTH-1:0] sync2;
    logic [CNT_W-1:0] cnt      [WIDTH];
    logic [CNT_W-1:0] cnt_next [WIDTH];
    logic [WIDTH-1:0] qualified;
    logic [WIDTH-1:0] deb_next;
    logic [WIDTH-1:0] rise_next;
    logic [WIDTH-1:0] fall_next;

    // NOTE: every clocked block uses non-blocking (<=) so all flops sample pre-edge values;
    // blocking here would collapse the two synchroniser stages into one.
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= sw_raw;
            sync2 <= sync1;
        end
    end

    always_comb begin
        // NOTE: defaults first so no path leaves a variable unassigned (which would infer a latch).
        qualified = '0;
        for (int i = 0; i < WIDTH; i++) begin
            cnt_next[i] = '0;
            if (sync2[i] != sw_debounced[i]) begin
                if (cnt[i] == CNT_LAST) begin
                    qualified[i] = 1'b1;
                end else begin
                    cnt_next[i] = cnt[i] + CNT_ONE;
                end
            end
        end
    end

    // Qualified bits adopt the synchronised level; the pulses are the direction of that change.
    assign deb_next  = (sw_debounced & ~qualified) | (sync2 & qualified);
    assign rise_next = qualified & sync2;
    assign fall_next = qualified & ~sync2;

    // NOTE: the counter array is reset explicitly; reset must discard any partial qualification,
    // so it cannot be left as an unreset memory.
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            for (int i = 0; i < WIDTH; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < WIDTH; i++) begin
                cnt[i] <= cnt_next[i];
            end
        end
    end

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            sw_debounced <= '0;
            sw_rise      <= '0;
            sw_fall      <= '0;
        end else begin
            sw_debounced <= deb_next;
            sw_rise      <= rise_next;
            sw_fall      <= fall_next;
        end
    end

    assign sw_changed = |(sw_rise | sw_fall);

`ifdef SWITCH_EVENT_LATCH_EN
    // Sticky flags: a pulse in the same cycle as a clear keeps the flag set.
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            evt_pending <= '0;
        end else begin
            evt_pending <= (evt_pending & ~evt_clear) | sw_rise | sw_fall;
        end
    end

    assign evt_irq = |evt_pending;
`endif

endmodule

// File: tb/tb_switch_debouncer.sv
// Self-checking bench for switch_debouncer with STABLE_CYCLES=4: table-driven phases
// plus hand-written bounce, reset-mid-count and (optional) event-latch sequences.
module tb_switch_debouncer;

    localparam int WIDTH = 8;

    logic             clk_clk = 1'b0;
    logic             reset_reset_n;
    logic [WIDTH-1:0] sw_raw;
    logic [WIDTH-1:0] sw_debounced;
    logic [WIDTH-1:0] sw_rise;
    logic [WIDTH-1:0] sw_fall;
    logic             sw_changed;
`ifdef SWITCH_EVENT_LATCH_EN
    logic [WIDTH-1:0] evt_clear;
    logic [WIDTH-1:0] evt_pending;
    logic             evt_irq;
`endif

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [7:0] raw;
        logic [7:0] deb;
        logic [7:0] rise;
        logic [7:0] fall;
        logic       chg;
    } vec_t;

    vec_t vecs[$];

    always #5 clk_clk = ~clk_clk;

    switch_debouncer #(
        .WIDTH        (WIDTH),
        .STABLE_CYCLES(4),
        .CNT_W        (20)
    ) dut (
        .clk_clk      (clk_clk),
        .reset_reset_n(reset_reset_n),
        .sw_raw       (sw_raw),
        .sw_debounced (sw_debounced),
        .sw_rise      (sw_rise),
        .sw_fall      (sw_fall),
        .sw_changed   (sw_changed)
`ifdef SWITCH_EVENT_LATCH_EN
        ,
        .evt_clear    (evt_clear),
        .evt_pending  (evt_pending),
        .evt_irq      (evt_irq)
`endif
    );

    task automatic tick();
        @(posedge clk_clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_outs(input string tag, input logic [7:0] deb, input logic [7:0] rise,
                              input logic [7:0] fall, input logic chg);
        check({tag, ".deb"},  32'(sw_debounced), 32'(deb));
        check({tag, ".rise"}, 32'(sw_rise),      32'(rise));
        check({tag, ".fall"}, 32'(sw_fall),      32'(fall));
        check({tag, ".chg"},  32'(sw_changed),   32'(chg));
    endtask

    // One raw change held for 7 edges: edges k..k+4 keep the old value, edge k+5 shows
    // the new value with its pulses, edge k+6 shows the pulses gone.
    function automatic void add_phase(input logic [7:0] raw, input logic [7:0] old_deb,
                                      input logic [7:0] rise, input logic [7:0] fall);
        vec_t v;
        for (int e = 0; e < 7; e++) begin
            v.raw  = raw;
            v.deb  = (e < 5) ? old_deb : raw;
            v.rise = (e == 5) ? rise : 8'h00;
            v.fall = (e == 5) ? fall : 8'h00;
            v.chg  = (e == 5) && ((rise | fall) != 8'h00);
            vecs.push_back(v);
        end
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        reset_reset_n = 1'b0;
        sw_raw        = 8'hFF;
`ifdef SWITCH_EVENT_LATCH_EN
        evt_clear     = 8'h00;
`endif
        repeat (3) tick();
        check_outs("reset", 8'h00, 8'h00, 8'h00, 1'b0);
`ifdef SWITCH_EVENT_LATCH_EN
        check("reset.pending", 32'(evt_pending), 32'h0);
        check("reset.irq",     32'(evt_irq),     32'h0);
`endif

        // Power-up rise, full fall, clean bit-0 toggle, then two simultaneous rise/fall pairs.
        add_phase(8'hFF, 8'h00, 8'hFF, 8'h00);
        add_phase(8'h00, 8'hFF, 8'h00, 8'hFF);
        add_phase(8'h01, 8'h00, 8'h01, 8'h00);
        add_phase(8'h04, 8'h01, 8'h04, 8'h01);
        add_phase(8'h02, 8'h04, 8'h02, 8'h04);

        reset_reset_n = 1'b1;
        for (int i = 0; i < vecs.size(); i++) begin
            sw_raw = vecs[i].raw;
            tick();
            check_outs($sformatf("vec%0d", i), vecs[i].deb, vecs[i].rise, vecs[i].fall, vecs[i].chg);
        end

        // Bounce on bit 3: 3 high / 3 low five times; the counter reaches 3 but never qualifies.
        for (int b = 0; b < 5; b++) begin
            sw_raw = 8'h0A;
            for (int c = 0; c < 3; c++) begin
                tick();
                check_outs($sformatf("bounce%0d_hi%0d", b, c), 8'h02, 8'h00, 8'h00, 1'b0);
            end
            sw_raw = 8'h02;
            for (int c = 0; c < 3; c++) begin
                tick();
                check_outs($sformatf("bounce%0d_lo%0d", b, c), 8'h02, 8'h00, 8'h00, 1'b0);
            end
        end
        sw_raw = 8'h0A;
        for (int c = 0; c < 5; c++) begin
            tick();
            check_outs($sformatf("settle%0d", c), 8'h02, 8'h00, 8'h00, 1'b0);
        end
        tick();
        check_outs("settle_rise", 8'h0A, 8'h08, 8'h00, 1'b1);
        tick();
        check_outs("settle_after", 8'h0A, 8'h00, 8'h00, 1'b0);

        // Reset after edge k+4, when bit 5's counter holds 3.
        sw_raw = 8'h20;
        for (int c = 0; c < 5; c++) begin
            tick();
            check_outs($sformatf("premid%0d", c), 8'h0A, 8'h00, 8'h00, 1'b0);
        end
        reset_reset_n = 1'b0;
        #1;
        check_outs("midreset", 8'h00, 8'h00, 8'h00, 1'b0);
        tick();
        reset_reset_n = 1'b1;
        for (int c = 0; c < 5; c++) begin
            tick();
            check_outs($sformatf("requal%0d", c), 8'h00, 8'h00, 8'h00, 1'b0);
        end
        tick();
        check_outs("requal_rise", 8'h20, 8'h20, 8'h00, 1'b1);
        tick();
        check_outs("requal_after", 8'h20, 8'h00, 8'h00, 1'b0);

`ifdef SWITCH_EVENT_LATCH_EN
        check("evt.pre_clear", 32'(evt_pending), 32'h20);
        evt_clear = 8'hFF;
        tick();
        evt_clear = 8'h00;
        check("evt.cleared", 32'(evt_pending), 32'h00);
        check("evt.cleared_irq", 32'(evt_irq), 32'h0);

        sw_raw = 8'h22;
        repeat (6) tick();
        check_outs("evt_rise", 8'h22, 8'h02, 8'h00, 1'b1);
        check("evt.before_set", 32'(evt_pending), 32'h00);
        tick();
        check("evt.set", 32'(evt_pending), 32'h02);
        check("evt.set_irq", 32'(evt_irq), 32'h1);

        sw_raw = 8'h20;
        repeat (6) tick();
        check_outs("evt_fall", 8'h20, 8'h00, 8'h02, 1'b1);
        evt_clear = 8'h02;
        tick();
        evt_clear = 8'h00;
        check("evt.set_wins", 32'(evt_pending), 32'h02);
        check("evt.set_wins_irq", 32'(evt_irq), 32'h1);
        tick();
        check("evt.held", 32'(evt_pending), 32'h02);
        evt_clear = 8'h02;
        tick();
        evt_clear = 8'h00;
        check("evt.clear_alone", 32'(evt_pending), 32'h00);
        check("evt.clear_alone_irq", 32'(evt_irq), 32'h0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
